// File: rtl/mem_wmst.sv
// mem_wmst: write master that drains a show-ahead FIFO of user words to
// consecutive (or fixed) word addresses on the shared memory port.
module mem_wmst #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 256,
    parameter int FIFO_AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_control_fixed_location,
    input  logic [31:0]       write_control_write_base,
    input  logic [31:0]       write_control_write_length,
    input  logic              write_control_go,
    output logic              write_control_done,
    input  logic              write_user_write_buffer,
    input  logic [DATA_W-1:0] write_user_buffer_input_data,
    output logic              write_user_buffer_full,
    output logic              wreq,
    input  logic              grant,
    output logic [31:0]       waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wen
);
    logic [31:0]        r_len;
    logic [31:0]        r_addr;
    logic               r_fixed;
    logic               r_wreq;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_cnt;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
    assign w_push  = write_user_write_buffer & ~w_full;
    assign w_pop   = grant & (r_len != '0) & ~w_empty & ~write_control_go;

    assign wen                    = w_pop;
    assign waddr                  = r_addr;
    assign wdata                  = r_mem[r_rp];
    assign wreq                   = r_wreq;
    assign write_control_done     = (r_len == '0);
    assign write_user_buffer_full = w_full;

    // go wins over a same-cycle write; a restart keeps queued FIFO words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_addr  <= '0;
            r_fixed <= 1'b0;
            r_wreq  <= 1'b0;
        end else if (write_control_go) begin
            r_len   <= write_control_write_length >> 4;
            r_addr  <= write_control_write_base >> 4;
            r_fixed <= write_control_fixed_location;
            r_wreq  <= (write_control_write_length >> 4) != '0;
        end else if (w_pop) begin
            r_len   <= r_len - 32'd1;
            r_addr  <= r_fixed ? r_addr : r_addr + 32'd1;
            r_wreq  <= (r_len != 32'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= w_push ? r_wp + FIFO_AW'(1) : r_wp;
            r_rp  <= w_pop ? r_rp + FIFO_AW'(1) : r_rp;
            r_cnt <= r_cnt + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= write_user_buffer_input_data;
    end
endmodule

// File: tb/tb_mem_wmst.sv
// tb_mem_wmst: scoreboard bench; pushed words queue up as expected write data,
// a behavioural model predicts wen/addr and every observed write is checked.
module tb_mem_wmst;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fixed = 1'b0;
    logic [31:0]  base = '0;
    logic [31:0]  len = '0;
    logic         go = 1'b0;
    logic         done;
    logic         push = 1'b0;
    logic [127:0] din = '0;
    logic         full;
    logic         wreq;
    logic         grant = 1'b0;
    logic [31:0]  waddr;
    logic [127:0] wdata;
    logic         wen;

    int n_tot = 0;
    int n_bad = 0;
    int nwr = 0;
    logic [127:0] q[$];
    logic [31:0]  m_len = '0;
    logic [31:0]  m_addr = '0;
    logic         m_fix = 1'b0;

    mem_wmst dut (
        .clk(clk), .rst(rst),
        .write_control_fixed_location(fixed),
        .write_control_write_base(base),
        .write_control_write_length(len),
        .write_control_go(go),
        .write_control_done(done),
        .write_user_write_buffer(push),
        .write_user_buffer_input_data(din),
        .write_user_buffer_full(full),
        .wreq(wreq), .grant(grant), .waddr(waddr), .wdata(wdata), .wen(wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model advances at negedge using the inputs held for the coming edge
    always @(negedge clk) begin
        logic ew;
        logic acc;
        if (rst) begin
            chk("rst_wen", wen, 0);
            chk("rst_wreq", wreq, 0);
            chk("rst_done", done, 1);
            chk("rst_full", full, 0);
            chk("rst_waddr", waddr, 0);
            q.delete();
            m_len = 0;
            m_addr = 0;
            m_fix = 0;
        end else begin
            ew = grant && m_len != 0 && q.size() != 0 && !go;
            chk("wen", wen, ew);
            chk("done", done, m_len == 0);
            chk("wreq", wreq, m_len != 0);
            chk("full", full, q.size() == 256);
            if (ew && wen) begin
                chk("waddr", waddr, m_addr);
                chk("wdata", wdata, q[0]);
                nwr++;
            end
            acc = push && q.size() < 256;
            if (go) begin
                m_len = len >> 4;
                m_addr = base >> 4;
                m_fix = fixed;
            end else if (ew) begin
                void'(q.pop_front());
                m_len = m_len - 1;
                if (!m_fix) m_addr = m_addr + 1;
            end
            if (acc) q.push_back(din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [127:0] d);
        push = 1'b1;
        din = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_go(input logic [31:0] b, input logic [31:0] l, input logic f);
        go = 1'b1;
        base = b;
        len = l;
        fixed = f;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int i = 0;
        while (!done && i < lim) begin
            tick();
            i++;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int n0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        // basic 4-word transfer
        for (int i = 0; i < 4; i++) do_push({32'hD0D0_0000 + i, 96'h1});
        grant = 1'b1;
        n0 = nwr;
        do_go(32'h1000, 32'h40, 1'b0);
        wait_done("t1_to", 20);
        tick();
        chk("t1_n", nwr - n0, 4);
        // empty FIFO, trickle pushes
        n0 = nwr;
        do_go(32'h0, 32'h30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_push({96'h0, 32'hA0 + i});
            tick();
            tick();
        end
        wait_done("t2_to", 20);
        chk("t2_n", nwr - n0, 3);
        // fixed location
        grant = 1'b0;
        do_push(128'h11);
        do_push(128'h22);
        n0 = nwr;
        do_go(32'h2000, 32'h20, 1'b1);
        grant = 1'b1;
        wait_done("t3_to", 20);
        chk("t3_n", nwr - n0, 2);
        // fill to full, overflow dropped, then drain
        grant = 1'b0;
        for (int i = 0; i < 257; i++) do_push({$urandom, $urandom, $urandom, 32'(i)});
        chk("t4_full", full, 1);
        chk("t4_q", q.size(), 256);
        n0 = nwr;
        grant = 1'b1;
        do_go(32'h0, 32'h1000, 1'b0);
        wait_done("t4_to", 400);
        chk("t4_n", nwr - n0, 256);
        chk("t4_empty", q.size(), 0);
        // zero and truncated lengths
        n0 = nwr;
        do_push(128'h55);
        do_go(32'h40, 32'h0, 1'b0);
        repeat (3) tick();
        chk("t5_zero_n", nwr - n0, 0);
        do_go(32'h40, 32'h1F, 1'b0);
        wait_done("t5_to", 10);
        chk("t5_n", nwr - n0, 1);
        // reset after two of four writes
        grant = 1'b0;
        for (int i = 0; i < 4; i++) do_push(128'hBEEF + i);
        n0 = nwr;
        do_go(32'h5000, 32'h40, 1'b0);
        grant = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_wen", wen, 0);
        chk("t6_done", done, 1);
        chk("t6_wreq", wreq, 0);
        chk("t6_n", nwr - n0, 2);
        tick();
        rst = 1'b0;
        tick();
        n0 = nwr;
        do_go(32'h6000, 32'h20, 1'b0);
        repeat (3) tick();
        chk("t6_flushed", nwr - n0, 0);
        do_push(128'hC0);
        do_push(128'hC1);
        wait_done("t6_to", 10);
        chk("t6_post_n", nwr - n0, 2);
        // go collides with grant and a non-empty FIFO
        grant = 1'b0;
        do_push(128'hE0);
        do_push(128'hE1);
        do_go(32'h3000, 32'h20, 1'b0);
        grant = 1'b1;
        n0 = nwr;
        go = 1'b1;
        base = 32'h4000;
        len = 32'h20;
        fixed = 1'b0;
        #1;
        chk("t6_prio_wen", wen, 0);
        tick();
        go = 1'b0;
        chk("t6_prio_n", nwr - n0, 0);
        wait_done("t6p_to", 10);
        chk("t6_prio_post", nwr - n0, 2);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
